// File: rtl/program_sequencer_pkg.sv
// Shared types and default encodings for the program sequencer.
package seq_pkg;

    // Run-control states; the encoding is visible to the host on the state port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

    // Host command encodings.
    typedef enum logic [1:0] {
        CMD_CLEAR = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_HALT  = 2'd3
    } seq_cmd_e;

    // Default instruction encodings for a 16-bit instruction word.
    localparam logic [15:0] DEF_NOP_INSTR  = 16'h0000;
    localparam logic [15:0] DEF_HALT_INSTR = 16'hFFFF;

endpackage

// File: rtl/program_sequencer_instr_mem.sv
// Instruction store: one synchronous write port for the host loader and one
// asynchronous read port so the fetched word follows pc with zero latency.
// Contents are deliberately never reset so a reset keeps the loaded program.
module instr_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

    // Host write; a read of the same address sees the old word until the edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Fetch and run controller: owns the program counter, issues instructions
// from the local instruction memory and handles run / step / halt control.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int                     PC_WIDTH    = 12,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = DEF_NOP_INSTR,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = DEF_HALT_INSTR,
    parameter int                     CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [PC_WIDTH-1:0]    load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd,
    output logic                   cmd_ready,
    input  logic                   bp_en,
    input  logic [PC_WIDTH-1:0]    bp_addr,
    output logic [PC_WIDTH-1:0]    program_counter,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   execution_enable,
    output logic [1:0]             state,
    output logic [CNT_WIDTH-1:0]   cycle_count
);

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    seq_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   resume_q, resume_d;

    logic [INSTR_WIDTH-1:0] fetched;
    logic                   active;
    logic                   bp_hit;
    logic                   stop;
    logic                   issue;
    logic                   mem_we;
    seq_cmd_e               cmd_e;

    assign cmd_e = seq_cmd_e'(cmd);

    instr_mem #(
        .ADDR_WIDTH (PC_WIDTH),
        .DATA_WIDTH (INSTR_WIDTH)
    ) u_instr_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (fetched)
    );

    // resume masks the breakpoint for the first fetch after RUN/STEP so the
    // host can continue from the address it stopped at.
    assign active     = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign bp_hit     = bp_en && (pc_q == bp_addr) && !resume_q;
    assign stop       = (fetched == HALT_INSTR) || bp_hit;
    assign issue      = active && !stop;

    assign load_ready = !active;
    assign mem_we     = load_valid && load_ready;

    assign cmd_ready        = 1'b1;
    assign execution_enable = issue;
    assign instruction      = issue ? fetched : NOP_INSTR;
    assign program_counter  = pc_q;
    assign state            = state_q;
    assign cycle_count      = cnt_q;

    // State, pc, cycle counter and resume flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            resume_q <= resume_d;
        end
    end

    // Next-state: advance on issue, then apply command / halt transitions.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        resume_d = resume_q;

        // Issue only happens in RUN/STEP, so this never collides with the
        // idle-state commands below.
        if (issue) begin
            pc_d     = pc_q + PC_ONE;
            resume_d = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (cmd_valid) begin
                    case (cmd_e)
                        CMD_CLEAR: begin
                            state_d = ST_IDLE;
                            pc_d    = '0;
                            cnt_d   = '0;
                        end
                        CMD_RUN: begin
                            state_d  = ST_RUN;
                            resume_d = 1'b1;
                        end
                        CMD_STEP: begin
                            state_d  = ST_STEP;
                            resume_d = 1'b1;
                        end
                        default: begin
                            // HALT while not running has no effect.
                        end
                    endcase
                end
            end
            ST_RUN: begin
                // A HALT command still lets the current issue complete.
                if (stop || (cmd_valid && (cmd_e == CMD_HALT))) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                // Either the single instruction issued or a stop condition
                // blocked it; both end the step.
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: reset, run, step, breakpoint,
// halt command, clear, load blocking and pc wrap.
module tb_program_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALTED = 2'd3;
    localparam logic [1:0] C_CLEAR = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_HALT = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [11:0] load_addr;
    logic [15:0] load_data;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic        bp_en;
    logic [11:0] bp_addr;
    logic [11:0] program_counter;
    logic [15:0] instruction;
    logic        execution_enable;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    program_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_addr        (load_addr),
        .load_data        (load_data),
        .cmd_valid        (cmd_valid),
        .cmd              (cmd),
        .cmd_ready        (cmd_ready),
        .bp_en            (bp_en),
        .bp_addr          (bp_addr),
        .program_counter  (program_counter),
        .instruction      (instruction),
        .execution_enable (execution_enable),
        .state            (state),
        .cycle_count      (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [11:0] a, input logic [15:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_pc(input logic [11:0] target, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            if (program_counter === target) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            if (state === target) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, S_IDLE); end
        checks++; if (program_counter !== 12'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", program_counter); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cycle_count); end
        checks++; if (execution_enable !== 1'b0) begin errors++; $display("FAIL reset_exec got %b exp 0", execution_enable); end
        checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", instruction); end
        checks++; if (load_ready !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b exp 11", load_ready, cmd_ready); end
        $display("reset: state=%0d pc=%0d cnt=%0d", state, program_counter, cycle_count);
    endtask

    // Words 0..11 are 16'h1000+i, word 12 is HALT.
    task automatic load_counting_program();
        for (int i = 0; i < 12; i++) load_word(12'(i), 16'h1000 + 16'(i));
        load_word(12'd12, 16'hFFFF);
        $display("load: words 0..11 = 1000+i, word 12 = FFFF");
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        send_cmd(C_RUN);
        wait_pc(12'd7, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrun_reach_pc7 got pc=%0d exp 7", program_counter); end
        checks++; if (instruction !== 16'h1007 || state !== S_RUN) begin errors++; $display("FAIL midrun_instr got %h/%0d exp 1007/1", instruction, state); end
        rst = 1'b1;
        #1;
        checks++; if (execution_enable !== 1'b0 || program_counter !== 12'd0 || state !== S_IDLE || cycle_count !== 32'd0) begin
            errors++; $display("FAIL midrun_async_reset got en=%b pc=%0d st=%0d cnt=%0d exp 0/0/0/0", execution_enable, program_counter, state, cycle_count);
        end
        #2;
        rst = 1'b0;
        tick();
        // Read word 3 back: stop at a breakpoint on 3, then step it out.
        bp_en = 1'b1; bp_addr = 12'd3;
        send_cmd(C_RUN);
        wait_state(S_HALTED, 20, ok);
        checks++; if (!ok || program_counter !== 12'd3 || cycle_count !== 32'd3) begin errors++; $display("FAIL bp3_halt got pc=%0d cnt=%0d exp 3/3", program_counter, cycle_count); end
        send_cmd(C_STEP);
        checks++; if (execution_enable !== 1'b1 || instruction !== 16'h1003) begin errors++; $display("FAIL mem_retained got en=%b instr=%h exp 1/1003", execution_enable, instruction); end
        tick();
        checks++; if (state !== S_HALTED || program_counter !== 12'd4) begin errors++; $display("FAIL step_after_bp got st=%0d pc=%0d exp 3/4", state, program_counter); end
        bp_en = 1'b0;
        $display("reset_mid_run: pc=%0d state=%0d", program_counter, state);
    endtask

    task automatic test_breakpoint();
        bit ok;
        send_cmd(C_CLEAR);
        bp_en = 1'b1; bp_addr = 12'd5;
        send_cmd(C_RUN);
        wait_state(S_HALTED, 20, ok);
        checks++; if (!ok || program_counter !== 12'd5 || cycle_count !== 32'd5) begin errors++; $display("FAIL bp5_halt got pc=%0d cnt=%0d exp 5/5", program_counter, cycle_count); end
        checks++; if (execution_enable !== 1'b0 || instruction !== 16'h0000) begin errors++; $display("FAIL bp5_nop got en=%b instr=%h exp 0/0000", execution_enable, instruction); end
        send_cmd(C_RUN);
        checks++; if (execution_enable !== 1'b1 || instruction !== 16'h1005) begin errors++; $display("FAIL bp5_resume got en=%b instr=%h exp 1/1005", execution_enable, instruction); end
        wait_pc(12'd10, 20, ok);
        checks++; if (!ok || state !== S_RUN || instruction !== 16'h100A) begin errors++; $display("FAIL bp5_continue got pc=%0d st=%0d instr=%h exp 10/1/100a", program_counter, state, instruction); end
        wait_state(S_HALTED, 20, ok);
        checks++; if (!ok || program_counter !== 12'd12 || cycle_count !== 32'd12) begin errors++; $display("FAIL halt_instr_stop got pc=%0d cnt=%0d exp 12/12", program_counter, cycle_count); end
        bp_en = 1'b0;
        $display("breakpoint: halted at pc=%0d cnt=%0d", program_counter, cycle_count);
    endtask

    task automatic test_halt_cmd();
        bit ok;
        send_cmd(C_CLEAR);
        send_cmd(C_RUN);
        wait_pc(12'd4, 20, ok);
        checks++; if (!ok || instruction !== 16'h1004) begin errors++; $display("FAIL halt_cmd_pc4 got pc=%0d instr=%h exp 4/1004", program_counter, instruction); end
        send_cmd(C_HALT);
        checks++; if (state !== S_HALTED || program_counter !== 12'd5 || cycle_count !== 32'd5) begin errors++; $display("FAIL halt_cmd got st=%0d pc=%0d cnt=%0d exp 3/5/5", state, program_counter, cycle_count); end
        send_cmd(C_CLEAR);
        checks++; if (state !== S_IDLE || program_counter !== 12'd0 || cycle_count !== 32'd0) begin errors++; $display("FAIL clear got st=%0d pc=%0d cnt=%0d exp 0/0/0", state, program_counter, cycle_count); end
        // Load attempt while running must be refused.
        send_cmd(C_RUN);
        load_valid = 1'b1; load_addr = 12'd8; load_data = 16'hDEAD;
        #1;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_blocked got ready=%b exp 0", load_ready); end
        tick();
        load_valid = 1'b0;
        wait_state(S_HALTED, 30, ok);
        send_cmd(C_CLEAR);
        bp_en = 1'b1; bp_addr = 12'd8;
        send_cmd(C_RUN);
        wait_state(S_HALTED, 20, ok);
        send_cmd(C_STEP);
        checks++; if (instruction !== 16'h1008) begin errors++; $display("FAIL load_unchanged got %h exp 1008", instruction); end
        tick();
        bp_en = 1'b0;
        $display("halt_cmd: clear and load-block done, pc=%0d", program_counter);
    endtask

    task automatic test_program();
        send_cmd(C_CLEAR);
        load_word(12'd0, 16'h1234);
        load_word(12'd1, 16'h5678);
        load_word(12'd2, 16'hFFFF);
        send_cmd(C_RUN);
        checks++; if (execution_enable !== 1'b1 || instruction !== 16'h1234) begin errors++; $display("FAIL prog_word0 got en=%b instr=%h exp 1/1234", execution_enable, instruction); end
        tick();
        checks++; if (execution_enable !== 1'b1 || instruction !== 16'h5678) begin errors++; $display("FAIL prog_word1 got en=%b instr=%h exp 1/5678", execution_enable, instruction); end
        tick();
        checks++; if (execution_enable !== 1'b0 || instruction !== 16'h0000) begin errors++; $display("FAIL prog_halt_nop got en=%b instr=%h exp 0/0000", execution_enable, instruction); end
        tick();
        checks++; if (state !== S_HALTED || program_counter !== 12'd2 || cycle_count !== 32'd2 || instruction !== 16'h0000) begin
            errors++; $display("FAIL prog_halted got st=%0d pc=%0d cnt=%0d instr=%h exp 3/2/2/0000", state, program_counter, cycle_count, instruction);
        end
        $display("program: halted pc=%0d cnt=%0d", program_counter, cycle_count);
    endtask

    task automatic test_step();
        send_cmd(C_CLEAR);
        send_cmd(C_STEP);
        checks++; if (state !== S_STEP || execution_enable !== 1'b1 || instruction !== 16'h1234) begin errors++; $display("FAIL step1_issue got st=%0d en=%b instr=%h exp 2/1/1234", state, execution_enable, instruction); end
        tick();
        checks++; if (state !== S_HALTED || program_counter !== 12'd1 || execution_enable !== 1'b0) begin errors++; $display("FAIL step1_done got st=%0d pc=%0d en=%b exp 3/1/0", state, program_counter, execution_enable); end
        send_cmd(C_STEP);
        checks++; if (instruction !== 16'h5678) begin errors++; $display("FAIL step2_issue got %h exp 5678", instruction); end
        tick();
        checks++; if (state !== S_HALTED || program_counter !== 12'd2 || cycle_count !== 32'd2) begin errors++; $display("FAIL step2_done got st=%0d pc=%0d cnt=%0d exp 3/2/2", state, program_counter, cycle_count); end
        send_cmd(C_STEP);
        checks++; if (execution_enable !== 1'b0) begin errors++; $display("FAIL step_on_halt got en=%b exp 0", execution_enable); end
        tick();
        checks++; if (state !== S_HALTED || program_counter !== 12'd2 || cycle_count !== 32'd2) begin errors++; $display("FAIL step_on_halt_done got st=%0d pc=%0d cnt=%0d exp 3/2/2", state, program_counter, cycle_count); end
        $display("step: pc=%0d cnt=%0d", program_counter, cycle_count);
    endtask

    task automatic test_wrap();
        bit ok;
        send_cmd(C_CLEAR);
        for (int i = 0; i < 4095; i++) load_word(12'(i), 16'h2000 + 16'(i));
        load_word(12'd4095, 16'hBEEF);
        bp_en = 1'b1; bp_addr = 12'd4095;
        send_cmd(C_RUN);
        wait_state(S_HALTED, 5000, ok);
        checks++; if (!ok || program_counter !== 12'd4095 || cycle_count !== 32'd4095) begin errors++; $display("FAIL wrap_reach got pc=%0d cnt=%0d exp 4095/4095", program_counter, cycle_count); end
        bp_en = 1'b0;
        send_cmd(C_RUN);
        checks++; if (instruction !== 16'hBEEF || execution_enable !== 1'b1) begin errors++; $display("FAIL wrap_last got instr=%h en=%b exp beef/1", instruction, execution_enable); end
        tick();
        checks++; if (program_counter !== 12'd0 || instruction !== 16'h2000) begin errors++; $display("FAIL wrap_zero got pc=%0d instr=%h exp 0/2000", program_counter, instruction); end
        send_cmd(C_HALT);
        checks++; if (state !== S_HALTED || program_counter !== 12'd1 || cycle_count !== 32'd4097) begin errors++; $display("FAIL wrap_halt got st=%0d pc=%0d cnt=%0d exp 3/1/4097", state, program_counter, cycle_count); end
        $display("wrap: pc=%0d cnt=%0d", program_counter, cycle_count);
    endtask

    initial begin
        rst = 1'b1;
        load_valid = 1'b0; load_addr = '0; load_data = '0;
        cmd_valid = 1'b0; cmd = '0;
        bp_en = 1'b0; bp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        test_reset();
        load_counting_program();
        test_reset_mid_run();
        test_breakpoint();
        test_halt_cmd();
        test_program();
        test_step();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Instruction-fetch and run controller for the cellular-automaton multiprocessor.
- Holds the program in a local instruction memory, loaded by a host port.
- Owns the fetch program counter and drives `instruction`, `program_counter` and `execution_enable` into the multiprocessor.
- Supports run, single-step, halt (command, HALT instruction or breakpoint) and a cycle counter for the host.

Parameters:
- PC_WIDTH, 12, fetch address width; memory depth is 2**PC_WIDTH.
- INSTR_WIDTH, 16, instruction width.
- NOP_INSTR, 16'h0000, instruction driven whenever not executing.
- HALT_INSTR, 16'hFFFF, encoding that stops execution.
- CNT_WIDTH, 32, cycle counter width.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  host write request.
- load_ready  out  1  write accepted this cycle when load_valid=1.
- load_addr  in  PC_WIDTH  write address.
- load_data  in  INSTR_WIDTH  write data.
- cmd_valid  in  1  command strobe; cmd_ready is tied to 1.
- cmd  in  2  00 CLEAR, 01 RUN, 10 STEP, 11 HALT.
- cmd_ready  out  1  constant 1.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_WIDTH  breakpoint address.
- program_counter  out  PC_WIDTH  current fetch address.
- instruction  out  INSTR_WIDTH  instruction to the multiprocessor.
- execution_enable  out  1  multiprocessor executes `instruction` this cycle.
- state  out  2  IDLE=0, RUN=1, STEP=2, HALTED=3.
- cycle_count  out  CNT_WIDTH  number of instructions issued.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - state=IDLE, pc=0, cycle_count=0, resume=0.
  - Memory contents are not cleared.
  - Outputs after reset: execution_enable=0, instruction=NOP_INSTR, load_ready=1.
- Fetch:
  - Combinational read: fetched = imem[pc].
  - issue = (state==RUN or STEP) and fetched != HALT_INSTR and not bp_hit.
  - bp_hit = bp_en and pc==bp_addr and not resume.
  - execution_enable=issue; instruction = issue ? fetched : NOP_INSTR. Latency 0 from pc to instruction.
- On each edge with issue=1:
  - pc <= pc+1, wrapping modulo 2**PC_WIDTH (4095 -> 0).
  - cycle_count saturates at all-ones.
  - resume <= 0.
- FSM:
  - IDLE/HALTED + RUN -> RUN, resume<=1.
  - IDLE/HALTED + STEP -> STEP, resume<=1.
  - RUN: fetched==HALT_INSTR or bp_hit -> HALTED; pc holds at that address and nothing issues.
  - RUN: HALT cmd -> HALTED. The instruction issued in the same cycle still executes and pc increments.
  - STEP: after one issue -> HALTED. If HALT_INSTR or bp_hit occurs first -> HALTED without issue.
  - CLEAR in IDLE/HALTED: pc<=0, cycle_count<=0, state<=IDLE.
  - CLEAR in RUN/STEP is ignored; RUN/STEP in RUN/STEP are ignored; HALT in IDLE/HALTED is ignored.
  - Simultaneous HALT_INSTR/bp_hit and HALT cmd -> HALTED, no issue, pc holds.
- resume semantics: a breakpoint at the resume address does not re-trigger on the first fetch after RUN/STEP.
- Load port:
  - load_ready=1 only in IDLE or HALTED.
  - Write occurs at the edge when load_valid and load_ready are both 1.
  - Read-during-write to the same address returns old data in that cycle and new data after the edge.
  - load_valid while in RUN/STEP is not accepted; the host must hold the request.

Decomposition:
- Package seq_pkg holds:
  - seq_state_e (IDLE, RUN, STEP, HALTED) and seq_cmd_e (CLEAR, RUN, STEP, HALT).
  - Default NOP_INSTR and HALT_INSTR constants.
- Sub-module instr_mem: 2**PC_WIDTH x INSTR_WIDTH, one synchronous write port, one asynchronous read port.
- FSM, pc and counter live in program_sequencer.

Test Plan:
- Reset during RUN at pc=7 -> the same cycle gives execution_enable=0, pc=0, state=0, cycle_count=0; memory word 3 written earlier still reads back.
- Load 16'h1234@0, 16'h5678@1, HALT_INSTR@2, then RUN -> instruction 1234 then 5678 with execution_enable=1; then state=HALTED, pc=2, cycle_count=2, instruction=0000.
- STEP twice from pc=0 on the same program -> each STEP issues exactly one instruction (1234, then 5678); state returns to HALTED; pc=1 then 2.
- bp_en=1, bp_addr=5, program of 10 NOP-free words, RUN -> halts with pc=5, cycle_count=5. A second RUN issues word 5 (resume) and continues to word 9 and beyond.
- HALT cmd during RUN at pc=4 -> word 4 issues, state=HALTED, pc=5. CLEAR -> pc=0, cycle_count=0, state=IDLE. load_valid during RUN -> load_ready=0 and the word is unchanged.
- pc=4095 with no HALT present, RUN -> word 4095 issues and the next fetch is address 0.
